// File: rtl/cpu_pkg.sv
//==============================================================================
// Module      : cpu_pkg
// Description : Shared CPU constants and types: address width, default reset
//               vector and the program-counter next-value select encoding.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam int                  c_ADDR_W       = 8;
    localparam logic [c_ADDR_W-1:0] c_RESET_VECTOR = 8'h00;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_JUMP = 2'd2,
        PC_RET  = 2'd3
    } pc_sel_e;

    // Sequential fetch address; the 8-bit result wraps 8'hFF -> 8'h00.
    function automatic logic [c_ADDR_W-1:0] next_seq_addr(input logic [c_ADDR_W-1:0] addr);
        return addr + c_ADDR_W'(1);
    endfunction

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/pc_return_stack.sv
//==============================================================================
// Module      : pc_return_stack
// Description : LIFO return-address stack with registered depth count. Entry
//               storage is not reset; only the depth is cleared.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_return_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = c_ADDR_W
) (
    input  logic                       clock,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full
);

    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_IDX_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_CNT_W-1:0] r_depth;
    logic [c_CNT_W-1:0] w_top;
    logic               w_push;
    logic               w_pop;

    // Requests are qualified here as well so the depth can never run past its
    // bounds, even if a caller misbehaves.
    assign w_push = push & ~pop & ~full;
    assign w_pop  = pop & ~push & ~empty;
    assign w_top  = r_depth - c_CNT_W'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_depth <= '0;
        end else if (w_push) begin
            r_depth <= r_depth + c_CNT_W'(1);
        end else if (w_pop) begin
            r_depth <= w_top;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && w_push) begin
            r_mem[r_depth[c_IDX_W-1:0]] <= din;
        end
    end

    assign dout  = r_mem[w_top[c_IDX_W-1:0]];
    assign depth = r_depth;
    assign empty = (r_depth == '0);
    assign full  = (r_depth == c_CNT_W'(DEPTH));

endmodule : pc_return_stack

`default_nettype wire

// File: rtl/program_counter.sv
//==============================================================================
// Module      : program_counter
// Description : 8-bit program counter with increment, jump and an optional
//               call/return stack (enabled by macro PC_CALL_STACK_EN).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module program_counter
    import cpu_pkg::*;
#(
    parameter logic [c_ADDR_W-1:0] RESET_VECTOR = c_RESET_VECTOR,
    parameter int                  STACK_DEPTH  = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                en_pc,
    input  logic                increment,
    input  logic                execute,
    input  logic [c_ADDR_W-1:0] jump_addr,
    input  logic                call,
    input  logic                ret,
    output logic [c_ADDR_W-1:0] pc,
    output logic                stack_empty,
    output logic                stack_full,
    output logic                stack_err
);

    logic [c_ADDR_W-1:0] r_pc;
    logic [c_ADDR_W-1:0] w_ret_addr;
    logic                w_exec;
    logic                w_inc;
    pc_sel_e             w_sel;

    assign w_exec = en_pc & execute;
    assign w_inc  = en_pc & increment & ~execute;

`ifdef PC_CALL_STACK_EN
    logic                           w_empty;
    logic                           w_full;
    logic                           w_call_ok;
    logic                           w_ret_ok;
    logic                           w_err;
    logic                           r_err;
    logic [$clog2(STACK_DEPTH+1)-1:0] w_depth_unused;

    assign w_call_ok = w_exec & call & ~ret & ~w_full;
    assign w_ret_ok  = w_exec & ret & ~call & ~w_empty;
    // Simultaneous call+ret, overflow and underflow all freeze pc and the stack.
    assign w_err     = w_exec & ((call & ret) | (call & w_full) | (ret & w_empty));

    pc_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (c_ADDR_W)
    ) u_stack (
        .clock (clock),
        .clear (clear),
        .push  (w_call_ok),
        .pop   (w_ret_ok),
        .din   (r_pc),
        .dout  (w_ret_addr),
        .depth (w_depth_unused),
        .empty (w_empty),
        .full  (w_full)
    );

    always_comb begin
        w_sel = PC_HOLD;
        if (w_err) begin
            w_sel = PC_HOLD;
        end else if (w_ret_ok) begin
            w_sel = PC_RET;
        end else if (w_exec) begin
            w_sel = PC_JUMP;
        end else if (w_inc) begin
            w_sel = PC_INC;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err;
        end
    end

    assign stack_empty = w_empty;
    assign stack_full  = w_full;
    assign stack_err   = r_err;
`else
    logic w_unused;

    // Without the stack, call/ret are don't-care and execute is a plain jump.
    assign w_unused   = &{1'b0, call, ret};
    assign w_ret_addr = '0;

    always_comb begin
        w_sel = PC_HOLD;
        if (w_exec) begin
            w_sel = PC_JUMP;
        end else if (w_inc) begin
            w_sel = PC_INC;
        end
    end

    assign stack_empty = 1'b1;
    assign stack_full  = 1'b0;
    assign stack_err   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            r_pc <= RESET_VECTOR;
        end else begin
            unique case (w_sel)
                PC_INC:  r_pc <= next_seq_addr(r_pc);
                PC_JUMP: r_pc <= jump_addr;
                PC_RET:  r_pc <= w_ret_addr;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign pc = r_pc;

endmodule : program_counter

`default_nettype wire

// File: tb/tb_program_counter.sv
//==============================================================================
// Module      : tb_program_counter
// Description : Directed self-checking bench for program_counter; expected
//               values follow the PC_CALL_STACK_EN build setting.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_program_counter;

`ifdef PC_CALL_STACK_EN
    localparam bit c_STK = 1'b1;
`else
    localparam bit c_STK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       clear;
    logic       en_pc;
    logic       increment;
    logic       execute;
    logic [7:0] jump_addr;
    logic       call;
    logic       ret;
    logic [7:0] pc;
    logic       stack_empty;
    logic       stack_full;
    logic       stack_err;

    int n_checks = 0;
    int n_errors = 0;

    program_counter #(
        .RESET_VECTOR (8'h00),
        .STACK_DEPTH  (4)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .en_pc       (en_pc),
        .increment   (increment),
        .execute     (execute),
        .jump_addr   (jump_addr),
        .call        (call),
        .ret         (ret),
        .pc          (pc),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic step(input logic cl, input logic en, input logic inc, input logic ex,
                        input logic cal, input logic rt, input logic [7:0] ja);
        clear     = cl;
        en_pc     = en;
        increment = inc;
        execute   = ex;
        call      = cal;
        ret       = rt;
        jump_addr = ja;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] ret_exp [4];
        clear = 1'b1; en_pc = 1'b0; increment = 1'b0; execute = 1'b0;
        call = 1'b0; ret = 1'b0; jump_addr = 8'h00;

        step(1, 0, 0, 0, 0, 0, 8'h00);
        check("reset_pc", pc, 8'h00);
        check("reset_empty", 8'(stack_empty), 8'h01);
        check("reset_full", 8'(stack_full), 8'h00);
        check("reset_err", 8'(stack_err), 8'h00);

        step(0, 1, 1, 0, 0, 0, 8'h00);
        check("inc1", pc, 8'h01);
        step(0, 1, 1, 0, 0, 0, 8'h00);
        check("inc2", pc, 8'h02);
        step(0, 1, 1, 0, 0, 0, 8'h00);
        check("inc3", pc, 8'h03);

        step(0, 1, 0, 1, 0, 0, 8'hFF);
        check("jump_ff", pc, 8'hFF);
        step(0, 1, 1, 0, 0, 0, 8'h00);
        check("wrap", pc, 8'h00);

        step(0, 0, 1, 1, 1, 0, 8'h77);
        check("hold_pc", pc, 8'h00);
        check("hold_empty", 8'(stack_empty), 8'h01);
        check("hold_err", 8'(stack_err), 8'h00);

        step(0, 1, 0, 1, 0, 0, 8'h10);
        check("jump_10", pc, 8'h10);
        step(0, 1, 1, 1, 0, 0, 8'h40);
        check("exec_wins", pc, 8'h40);

        step(0, 1, 0, 0, 1, 0, 8'h99);
        check("noexec_call_pc", pc, 8'h40);
        check("noexec_call_empty", 8'(stack_empty), 8'h01);
        check("noexec_call_err", 8'(stack_err), 8'h00);

        step(0, 1, 0, 1, 0, 0, 8'h21);
        check("jump_21", pc, 8'h21);
        step(0, 1, 0, 1, 1, 0, 8'h80);
        check("call_80", pc, 8'h80);
        check("call_empty", 8'(stack_empty), c_STK ? 8'h00 : 8'h01);
        step(0, 1, 0, 1, 0, 1, 8'h55);
        check("ret_21", pc, c_STK ? 8'h21 : 8'h55);
        check("ret_empty", 8'(stack_empty), 8'h01);

        // Fill the four-entry stack; return addresses are the pc before each call.
        ret_exp[0] = pc;
        ret_exp[1] = 8'hA0;
        ret_exp[2] = 8'hA1;
        ret_exp[3] = 8'hA2;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1, 1, 0, 8'hA0 + 8'(i));
            check("fill_call", pc, 8'hA0 + 8'(i));
        end
        check("full_set", 8'(stack_full), c_STK ? 8'h01 : 8'h00);
        check("full_not_empty", 8'(stack_empty), c_STK ? 8'h00 : 8'h01);

        step(0, 1, 0, 1, 1, 0, 8'hB0);
        check("overflow_pc", pc, c_STK ? 8'hA3 : 8'hB0);
        check("overflow_err", 8'(stack_err), c_STK ? 8'h01 : 8'h00);
        step(0, 0, 0, 0, 0, 0, 8'h00);
        check("err_pulse_end", 8'(stack_err), 8'h00);
        check("idle_pc", pc, c_STK ? 8'hA3 : 8'hB0);

        for (int i = 3; i >= 0; i--) begin
            step(0, 1, 0, 1, 0, 1, 8'h66);
            check("unwind_ret", pc, c_STK ? ret_exp[i] : 8'h66);
        end
        check("unwind_empty", 8'(stack_empty), 8'h01);
        check("unwind_full", 8'(stack_full), 8'h00);

        step(0, 1, 0, 1, 0, 1, 8'h66);
        check("underflow_pc", pc, c_STK ? ret_exp[0] : 8'h66);
        check("underflow_err", 8'(stack_err), c_STK ? 8'h01 : 8'h00);

        step(0, 1, 0, 1, 1, 1, 8'hC0);
        check("callret_pc", pc, c_STK ? ret_exp[0] : 8'hC0);
        check("callret_err", 8'(stack_err), c_STK ? 8'h01 : 8'h00);

        step(0, 1, 0, 1, 1, 0, 8'h90);
        check("call_90", pc, 8'h90);
        check("call_90_err", 8'(stack_err), 8'h00);
        step(1, 1, 0, 1, 1, 0, 8'hE0);
        check("clear_call_pc", pc, 8'h00);
        check("clear_call_empty", 8'(stack_empty), 8'h01);
        check("clear_call_full", 8'(stack_full), 8'h00);
        check("clear_call_err", 8'(stack_err), 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_program_counter

`default_nettype wire
